// File: rtl/cgra_cfg_pkg.sv
// rtl/cgra_cfg_pkg.sv - shared config-chain word width and loader state encoding
package cgra_cfg_pkg;

    localparam int CFG_WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } cfg_load_state_t;

endpackage

// File: rtl/config_rb_packer.sv
// rtl/config_rb_packer.sv - packs serial chain-tail samples LSB-first into readback words
module config_rb_packer
    import cgra_cfg_pkg::*;
#(
    parameter int WORD_W = CFG_WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              sample_en,
    input  logic              sample_bit,
    input  logic              flush,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
);
    localparam int IDX_W = $clog2(WORD_W);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

    logic [WORD_W-1:0] acc;
    logic [WORD_W-1:0] acc_next;
    logic [IDX_W-1:0]  idx;

    // Current partial word with the incoming sample merged in at its bit position
    always_comb begin
        acc_next      = acc;
        acc_next[idx] = sample_bit;
    end

    // Accumulate samples; emit a word when full or when the load ends (upper bits stay zero)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            idx      <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (sample_en) begin
                if (idx == IDX_LAST || flush) begin
                    rb_data  <= acc_next;
                    rb_valid <= 1'b1;
                    acc      <= '0;
                    idx      <= '0;
                end else begin
                    acc <= acc_next;
                    idx <= idx + IDX_W'(1);
                end
            end else if (clear) begin
                acc <= '0;
                idx <= '0;
            end
        end
    end

endmodule

// File: rtl/config_stream_loader.sv
// rtl/config_stream_loader.sv - serial config-chain writer; CONFIG_READBACK_EN adds tail readback
module config_stream_loader
    import cgra_cfg_pkg::*;
#(
    parameter int WORD_W    = CFG_WORD_W,
    parameter int CHAIN_LEN = 100
) (
    input  logic              Config_Clock,
    input  logic              Config_Reset,
    input  logic              start,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ConfigOut,
    output logic              cfg_shift_en,
    output logic              busy,
    output logic              done,
    input  logic              ConfigIn,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
);
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int BI_W  = $clog2(WORD_W);
    localparam logic [BI_W-1:0]  BI_LAST  = BI_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] REM_INIT = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] REM_ONE  = CNT_W'(1);

    cfg_load_state_t   state;
    cfg_load_state_t   state_next;
    logic [WORD_W-1:0] sr;
    logic [BI_W-1:0]   bi;
    logic [CNT_W-1:0]  rem;
    logic              sr_full;
    logic              start_load;
    logic              accept;

    // Next state and ready: refill when empty, or on the cycle the last bit of a word leaves
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        start_load = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = LOAD;
                    start_load = 1'b1;
                end
            end
            LOAD: begin
                in_ready = !sr_full || (bi == BI_LAST && rem > REM_ONE);
                if (sr_full && rem == REM_ONE) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = in_ready && in_valid;

    // State register
    always_ff @(posedge Config_Clock or negedge Config_Reset) begin
        if (!Config_Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Shift datapath: one bit per cycle while the word register holds data, stall otherwise
    always_ff @(posedge Config_Clock or negedge Config_Reset) begin
        if (!Config_Reset) begin
            sr           <= '0;
            bi           <= '0;
            rem          <= '0;
            sr_full      <= 1'b0;
            ConfigOut    <= 1'b0;
            cfg_shift_en <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            cfg_shift_en <= 1'b0;
            if (start_load) begin
                rem     <= REM_INIT;
                bi      <= '0;
                sr_full <= 1'b0;
                busy    <= 1'b1;
                done    <= 1'b0;
            end else if (state == LOAD) begin
                if (sr_full) begin
                    ConfigOut    <= sr[bi];
                    cfg_shift_en <= 1'b1;
                    rem          <= rem - REM_ONE;
                    if (rem == REM_ONE) begin
                        sr_full <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (bi == BI_LAST) begin
                        if (accept) begin
                            sr <= in_data;
                            bi <= '0;
                        end else begin
                            sr_full <= 1'b0;
                        end
                    end else begin
                        bi <= bi + BI_W'(1);
                    end
                end else if (accept) begin
                    sr      <= in_data;
                    bi      <= '0;
                    sr_full <= 1'b1;
                end
            end
        end
    end

`ifdef CONFIG_READBACK_EN
    // The final shift cycle is the only one where done is already set, so it marks the flush
    config_rb_packer #(
        .WORD_W(WORD_W)
    ) u_rb_packer (
        .clk       (Config_Clock),
        .rst_n     (Config_Reset),
        .clear     (start_load),
        .sample_en (cfg_shift_en),
        .sample_bit(ConfigIn),
        .flush     (done),
        .rb_data   (rb_data),
        .rb_valid  (rb_valid)
    );
`else
    logic unused_config_in;
    assign unused_config_in = ConfigIn;
    assign rb_data          = '0;
    assign rb_valid         = 1'b0;
`endif

endmodule

// File: tb/tb_config_stream_loader.sv
// tb/tb_config_stream_loader.sv - self-checking bench for config_stream_loader
module tb_config_stream_loader;
    import cgra_cfg_pkg::*;

    localparam int W  = CFG_WORD_W;
    localparam int L  = 100;
    localparam int L2 = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         start = 1'b0, in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready, config_out, cfg_shift_en, busy, done, config_in, rb_valid;
    logic [W-1:0] rb_data;

    logic         start32 = 1'b0, in_valid32 = 1'b0, config_in32 = 1'b0;
    logic [W-1:0] in_data32 = '0;
    logic         in_ready32, config_out32, cfg_shift_en32, busy32, done32, rb_valid32;
    logic [W-1:0] rb_data32;

    config_stream_loader #(.WORD_W(W), .CHAIN_LEN(L)) dut (
        .Config_Clock(clk), .Config_Reset(rst_n), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .ConfigOut(config_out),
        .cfg_shift_en(cfg_shift_en), .busy(busy), .done(done), .ConfigIn(config_in),
        .rb_data(rb_data), .rb_valid(rb_valid)
    );

    config_stream_loader #(.WORD_W(W), .CHAIN_LEN(L2)) dut32 (
        .Config_Clock(clk), .Config_Reset(rst_n), .start(start32), .in_data(in_data32),
        .in_valid(in_valid32), .in_ready(in_ready32), .ConfigOut(config_out32),
        .cfg_shift_en(cfg_shift_en32), .busy(busy32), .done(done32), .ConfigIn(config_in32),
        .rb_data(rb_data32), .rb_valid(rb_valid32)
    );

    // Behavioural chain: index 0 is the head cell, L-1 the tail feeding ConfigIn
    logic [L-1:0] chain = '0;
    assign config_in = chain[L-1];
    always @(posedge clk) if (cfg_shift_en) chain <= {chain[L-2:0], config_out};

    int checks = 0;
    int failures = 0;

    int   cyc = 0, stalls = 0, unstable = 0;
    logic in_run = 1'b0, last_bit = 1'b0;
    logic         bits_q[$];
    int           shift_cyc_q[$];
    logic         bits32_q[$];
    logic [W-1:0] rb_q[$];
    logic [W-1:0] wq[$];

    // Observe the serial stream, stall behaviour and readback pulses
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (cfg_shift_en) begin
            bits_q.push_back(config_out);
            shift_cyc_q.push_back(cyc);
            last_bit <= config_out;
            in_run   <= 1'b1;
        end else if (busy && in_run) begin
            stalls <= stalls + 1;
            if (config_out !== last_bit) unstable <= unstable + 1;
        end else if (!busy) begin
            in_run <= 1'b0;
        end
        if (rb_valid) rb_q.push_back(rb_data);
        if (cfg_shift_en32) bits32_q.push_back(config_out32);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic exp_bit(input int i);
        logic [W-1:0] w;
        w = wq[i / W];
        return w[i % W];
    endfunction

    function automatic int bit_errors(input int base, input int n);
        int e = 0;
        for (int i = 0; i < n; i++) begin
            if (base + i >= bits_q.size()) e++;
            else if (bits_q[base + i] !== exp_bit(i)) e++;
        end
        return e;
    endfunction

    function automatic int span(input int base, input int n);
        if (base + n > shift_cyc_q.size()) return -1;
        return shift_cyc_q[base + n - 1] - shift_cyc_q[base] + 1;
    endfunction

    function automatic void random_words();
        wq.delete();
        for (int k = 0; k < (L + W - 1) / W; k++) wq.push_back($urandom);
    endfunction

    task automatic drive_load(input bit do_start, input int gap_idx, input int gap,
                              input int restart_idx, output int accepts, output int extra,
                              output bit timeout);
        int guard;
        accepts = 0; extra = 0; timeout = 1'b0;
        if (do_start) begin
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
        end
        for (int k = 0; k < wq.size() && !timeout; k++) begin
            in_data = wq[k]; in_valid = 1'b1; guard = 0;
            while (!in_ready && guard < 200) begin @(negedge clk); guard++; end
            if (!in_ready) timeout = 1'b1;
            else begin
                @(negedge clk);
                accepts++;
                if (k == restart_idx) begin start = 1'b1; @(negedge clk); start = 1'b0; end
                if (k == gap_idx) begin in_valid = 1'b0; repeat (W - 1 + gap) @(negedge clk); end
            end
        end
        in_data = $urandom; in_valid = 1'b1; guard = 0;
        while (!done && guard < 400) begin
            if (in_ready) extra++;
            @(negedge clk); guard++;
        end
        if (!done) timeout = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1;
        repeat (3) @(negedge clk);
        if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        checks++;
        if (config_out !== 1'b0) begin failures++; $display("FAIL reset_config_out got %b want 0", config_out); end
        checks++;
        if (cfg_shift_en !== 1'b0) begin failures++; $display("FAIL reset_shift_en got %b want 0", cfg_shift_en); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy_start_held got %b want 0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", done); end
        checks++;
        if (rb_valid !== 1'b0 || rb_data !== '0) begin failures++; $display("FAIL reset_rb got %b/%h want 0/0", rb_valid, rb_data); end
        checks++;
        start = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        in_valid = 1'b1; in_data = $urandom;
        repeat (3) @(negedge clk);
        if (in_ready !== 1'b0 || cfg_shift_en !== 1'b0) begin
            failures++; $display("FAIL idle_ignores_valid got ready=%b shift=%b want 0/0", in_ready, cfg_shift_en);
        end
        checks++;
        in_valid = 1'b0;
    endtask

    task automatic test_fixed_words();
        int base, st, acc, extra; bit to;
        wq.delete();
        wq.push_back(32'hA5A5A5A5); wq.push_back(32'h0F0F0F0F);
        wq.push_back(32'hFFFFFFFF); wq.push_back(32'h00000003);
        base = bits_q.size(); st = stalls;
        drive_load(1'b1, -1, 0, -1, acc, extra, to);
        if (to !== 1'b0) begin failures++; $display("FAIL fixed_timeout got %0d want 0", to); end
        checks++;
        if (acc != 4 || extra != 0) begin failures++; $display("FAIL fixed_handshakes got %0d extra %0d want 4 extra 0", acc, extra); end
        checks++;
        if (bits_q.size() - base != L) begin failures++; $display("FAIL fixed_bit_count got %0d want %0d", bits_q.size() - base, L); end
        checks++;
        if (bit_errors(base, L) != 0) begin failures++; $display("FAIL fixed_bits got %0d wrong want 0", bit_errors(base, L)); end
        checks++;
        if (span(base, L) != L || stalls != st) begin failures++; $display("FAIL fixed_contiguous got span %0d want %0d", span(base, L), L); end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++; $display("FAIL fixed_end_flags got done=%b busy=%b ready=%b want 1/0/0", done, busy, in_ready);
        end
        checks++;
    endtask

    task automatic test_stall();
        int base, st, us, acc, extra; bit to;
        random_words();
        base = bits_q.size(); st = stalls; us = unstable;
        drive_load(1'b1, 1, 5, -1, acc, extra, to);
        if (to !== 1'b0 || bits_q.size() - base != L) begin
            failures++; $display("FAIL stall_bit_count got %0d want %0d", bits_q.size() - base, L);
        end
        checks++;
        if (bit_errors(base, L) != 0) begin failures++; $display("FAIL stall_bits got %0d wrong want 0", bit_errors(base, L)); end
        checks++;
        if (stalls - st != 5 || span(base, L) != L + 5) begin
            failures++; $display("FAIL stall_cycles got %0d span %0d want 5 span %0d", stalls - st, span(base, L), L + 5);
        end
        checks++;
        if (unstable != us) begin failures++; $display("FAIL stall_config_out_held got %0d changes want 0", unstable - us); end
        checks++;
    endtask

    task automatic test_back_to_back();
        int base, st, acc, extra, gi, gl; bit to;
        for (int it = 0; it < 3; it++) begin
            random_words();
            gi = $urandom_range(0, 2); gl = $urandom_range(0, 4);
            base = bits_q.size(); st = stalls;
            drive_load(1'b1, gi, gl, -1, acc, extra, to);
            if (to !== 1'b0 || acc != 4 || bit_errors(base, L) != 0 || bits_q.size() - base != L) begin
                failures++; $display("FAIL b2b_load%0d got %0d bits %0d wrong want %0d bits 0 wrong", it, bits_q.size() - base, bit_errors(base, L), L);
            end
            checks++;
            if (stalls - st != gl) begin failures++; $display("FAIL b2b_stalls%0d got %0d want %0d", it, stalls - st, gl); end
            checks++;
        end
    endtask

    task automatic test_start_ignored();
        int base, acc, extra; bit to;
        random_words();
        base = bits_q.size();
        drive_load(1'b1, -1, 0, 1, acc, extra, to);
        if (to !== 1'b0 || bits_q.size() - base != L || bit_errors(base, L) != 0) begin
            failures++; $display("FAIL start_in_load got %0d bits %0d wrong want %0d bits 0 wrong", bits_q.size() - base, bit_errors(base, L), L);
        end
        checks++;
        if (span(base, L) != L) begin failures++; $display("FAIL start_in_load_span got %0d want %0d", span(base, L), L); end
        checks++;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        #1;
        if (done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL start_in_done got done=%b busy=%b want 0/1", done, busy); end
        checks++;
        random_words();
        base = bits_q.size();
        drive_load(1'b0, -1, 0, -1, acc, extra, to);
        if (to !== 1'b0 || bit_errors(base, L) != 0 || done !== 1'b1) begin
            failures++; $display("FAIL reload_after_done got %0d wrong done=%b want 0 wrong done=1", bit_errors(base, L), done);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        int base, k, acc, extra; bit to;
        random_words();
        base = bits_q.size(); k = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int g = 0; g < 300; g++) begin
            @(negedge clk); #1;
            if (bits_q.size() - base >= 40) break;
            if (k < wq.size()) begin
                in_data = wq[k]; in_valid = 1'b1;
                if (in_ready) k++;
            end
        end
        if (bits_q.size() - base != 40 || cfg_shift_en !== 1'b1) begin
            failures++; $display("FAIL abort_point got %0d bits shift=%b want 40 shift=1", bits_q.size() - base, cfg_shift_en);
        end
        checks++;
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        if (cfg_shift_en !== 1'b0 || config_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
            failures++; $display("FAIL abort_reset_outputs got shift=%b out=%b busy=%b done=%b ready=%b want all 0",
                                 cfg_shift_en, config_out, busy, done, in_ready);
        end
        checks++;
        @(negedge clk); rst_n = 1'b1;
        random_words();
        base = bits_q.size();
        drive_load(1'b1, -1, 0, -1, acc, extra, to);
        if (to !== 1'b0 || bits_q.size() - base != L || bit_errors(base, L) != 0) begin
            failures++; $display("FAIL abort_reload got %0d bits %0d wrong want %0d bits 0 wrong", bits_q.size() - base, bit_errors(base, L), L);
        end
        checks++;
    endtask

    task automatic test_chain32();
        int base, hs, errs;
        logic [W-1:0] word;
        word = $urandom; base = bits32_q.size(); hs = 0;
        @(negedge clk); start32 = 1'b1;
        @(negedge clk); start32 = 1'b0;
        in_data32 = word; in_valid32 = 1'b1;
        for (int g = 0; g < 60; g++) begin
            if (in_ready32) hs++;
            @(negedge clk);
            in_data32 = $urandom;
            if (done32) break;
        end
        in_valid32 = 1'b0;
        repeat (2) @(negedge clk);
        if (hs != 1) begin failures++; $display("FAIL len32_handshakes got %0d want 1", hs); end
        checks++;
        errs = 0;
        for (int i = 0; i < L2; i++) begin
            if (base + i >= bits32_q.size()) errs++;
            else if (bits32_q[base + i] !== word[i]) errs++;
        end
        if (bits32_q.size() - base != L2 || errs != 0) begin
            failures++; $display("FAIL len32_bits got %0d bits %0d wrong want %0d bits 0 wrong", bits32_q.size() - base, errs, L2);
        end
        checks++;
        if (done32 !== 1'b1 || busy32 !== 1'b0) begin failures++; $display("FAIL len32_done got done=%b busy=%b want 1/0", done32, busy32); end
        checks++;
    endtask

    task automatic test_readback();
        int rbbase, acc, extra, errs; bit to;
        logic [W-1:0] pq[$];
        logic [W-1:0] expw, pw;
        random_words();
        drive_load(1'b1, -1, 0, -1, acc, extra, to);
        pq = wq;
        random_words();
        rbbase = rb_q.size();
        drive_load(1'b1, -1, 0, -1, acc, extra, to);
        repeat (2) @(negedge clk);
        errs = 0;
        for (int i = 0; i < L; i++) if (chain[L - 1 - i] !== exp_bit(i)) errs++;
        if (to !== 1'b0 || errs != 0) begin failures++; $display("FAIL chain_holds_q got %0d wrong want 0", errs); end
        checks++;
`ifdef CONFIG_READBACK_EN
        if (rb_q.size() - rbbase != 4) begin failures++; $display("FAIL rb_pulses got %0d want 4", rb_q.size() - rbbase); end
        checks++;
        for (int j = 0; j < 4; j++) begin
            expw = '0; pw = pq[j];
            for (int b = 0; b < W; b++) if (j * W + b < L) expw[b] = pw[b];
            if (rbbase + j < rb_q.size()) begin
                if (rb_q[rbbase + j] !== expw) begin failures++; $display("FAIL rb_word%0d got %h want %h", j, rb_q[rbbase + j], expw); end
                checks++;
            end
        end
`else
        if (rb_q.size() != 0) begin failures++; $display("FAIL rb_disabled got %0d pulses want 0", rb_q.size()); end
        checks++;
`endif
    endtask

    initial begin
        test_reset();
        test_fixed_words();
        test_stall();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
        test_chain32();
        test_readback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
